// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Optional memory-wait timeout is built when MEM_TIMEOUT_EN is defined.
module multicycle_controller #(
    parameter int unsigned WAIT_MAX  = 16,
    parameter int unsigned ALUCTRL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    input  logic                 imem_ready,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ready,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic                 dec_branch,
    input  logic                 dec_regWrite,
    input  logic                 dec_JAL,
    input  logic                 dec_JALR,
    input  logic                 dec_AUIPC,
    input  logic [ALUCTRL_W-1:0] dec_aluCtrl,
    input  logic                 branch_taken,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 retire,
    output logic [31:0]          instret,
    output logic [2:0]           state,
    output logic                 illegal,
    output logic                 bus_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ILLEGAL = ALUCTRL_W'(5'b01111);

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;

    // AUIPC only steers datapath muxes; it has no sequencing effect here.
    logic unused_auipc;
    assign unused_auipc = dec_AUIPC;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bus_err_q, bus_err_d;
    logic              timeout_c;

    // Count consecutive stalled request cycles; any ready or idle cycle clears.
    always_comb begin
        wait_d = '0;
        if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    assign timeout_c = (wait_q == WAIT_LAST);
    assign bus_err   = bus_err_q;
`else
    logic unused_wait_max;
    assign unused_wait_max = ^WAIT_MAX;
    assign bus_err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_q    <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
`ifdef MEM_TIMEOUT_EN
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    // Next state and strobe decode.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
`ifdef MEM_TIMEOUT_EN
        bus_err_d = bus_err_q;
`endif
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_c) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
`endif
            end
            S_DECODE: begin
                if (dec_aluCtrl == ALU_ILLEGAL) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_load || dec_store) begin
                    state_d = S_MEM;
                end else if (dec_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_store;
                if (dmem_ready) begin
                    if (dec_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_c) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end
`endif
            end
            S_WB: begin
                rf_we = dec_regWrite;
                if (dec_load) begin
                    wb_sel = 2'b01;
                end else if (dec_JAL || dec_JALR) begin
                    wb_sel = 2'b10;
                end
                pc_we = 1'b1;
                if (dec_JAL) begin
                    pc_sel = 2'b01;
                end else if (dec_JALR) begin
                    pc_sel = 2'b10;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign instret_d = retire ? (instret_q + 32'd1) : instret_q;

    assign instret = instret_q;
    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: driver pushes expected retire records,
// a negedge monitor pops and checks them whenever the DUT retires.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready;
    logic        dmem_req, dmem_we, dmem_ready;
    logic        dec_load, dec_store, dec_branch, dec_regWrite;
    logic        dec_JAL, dec_JALR, dec_AUIPC;
    logic [4:0]  dec_aluCtrl;
    logic        branch_taken;
    logic        ir_we, pc_we, rf_we, retire;
    logic [1:0]  pc_sel, wb_sel;
    logic [31:0] instret;
    logic [2:0]  state;
    logic        illegal, bus_err;

    multicycle_controller #(.WAIT_MAX(4), .ALUCTRL_W(5)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .dec_load(dec_load), .dec_store(dec_store), .dec_branch(dec_branch),
        .dec_regWrite(dec_regWrite), .dec_JAL(dec_JAL), .dec_JALR(dec_JALR),
        .dec_AUIPC(dec_AUIPC), .dec_aluCtrl(dec_aluCtrl),
        .branch_taken(branch_taken),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .retire(retire), .instret(instret), .state(state),
        .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  pc_sel;
        logic [1:0]  wb_sel;
        logic        rf_we;
        logic [31:0] instret;
        logic [7:0]  lat;
        logic [7:0]  mem_cyc;
        logic        mem_we;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: validates every retire against the oldest queued expectation.
    int cyc = 0, start_cyc = 0, mem_cnt = 0;
    logic mem_we_seen = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (ir_we === 1'b1) begin start_cyc = cyc; mem_cnt = 0; end
            if (dmem_req === 1'b1) begin mem_cnt++; mem_we_seen = dmem_we; end
            if (retire === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL retire_unexpected: got retire=1 expected none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("ret_pc_we",   32'(pc_we),  32'd1);
                    chk("ret_pc_sel",  32'(pc_sel), 32'(e.pc_sel));
                    chk("ret_wb_sel",  32'(wb_sel), 32'(e.wb_sel));
                    chk("ret_rf_we",   32'(rf_we),  32'(e.rf_we));
                    chk("ret_instret", instret,     e.instret);
                    chk("ret_latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
                    chk("ret_mem_cyc", 32'(mem_cnt), 32'(e.mem_cyc));
                    if (e.mem_cyc != 8'd0) chk("ret_mem_we", 32'(mem_we_seen), 32'(e.mem_we));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic wait_state(input logic [2:0] s);
        int k = 0;
        while (state !== s && k < 30) begin tick(); k++; end
        if (k == 30) begin
            n_chk++;
            $display("FAIL wait_state: got state=%0d expected %0d", state, s);
        end
    endtask

    // Issues one instruction; entered and left in FETCH at posedge+1.
    task automatic do_instr(input logic [5:0] f, input logic [4:0] alu, input logic tk,
                            input int imem_wait, input int dmem_wait, input exp_t e);
        sb.push_back(e);
        {dec_load, dec_store, dec_branch, dec_regWrite, dec_JAL, dec_JALR} = f;
        dec_aluCtrl  = alu;
        branch_taken = tk;
        imem_ready   = 1'b0;
        repeat (imem_wait) tick();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        if (f[5] || f[4]) begin
            wait_state(3'd3);
            repeat (dmem_wait) tick();
            dmem_ready = 1'b1;
            tick();
            dmem_ready = 1'b0;
        end
        wait_state(3'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // flags: {load, store, branch, regWrite, JAL, JALR}
    initial begin
        rst = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        {dec_load, dec_store, dec_branch, dec_regWrite, dec_JAL, dec_JALR, dec_AUIPC} = '0;
        dec_aluCtrl = 5'b00000; branch_taken = 1'b0;
        repeat (2) tick();
        chk("rst_state",   32'(state),    32'd0);
        chk("rst_instret", instret,       32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_strobes", 32'({ir_we, pc_we, rf_we, dmem_req, retire, pc_sel, wb_sel}), 32'd0);
        chk("rst_flags",   32'({illegal, bus_err}), 32'd0);
        rst = 1'b0;

        //                                    pc    wb    rf instret lat mem we
        do_instr(6'b000100, 5'b00001, 1'b0, 0, 0, '{2'b00, 2'b00, 1'b1, 32'd0, 8'd4, 8'd0, 1'b0}); // ADDI
        chk("addi_instret", instret, 32'd1);
        do_instr(6'b100100, 5'b00001, 1'b0, 0, 3, '{2'b00, 2'b01, 1'b1, 32'd1, 8'd8, 8'd4, 1'b0}); // LW slow
        do_instr(6'b001000, 5'b00010, 1'b1, 0, 0, '{2'b01, 2'b00, 1'b0, 32'd2, 8'd3, 8'd0, 1'b0}); // BEQ taken
        do_instr(6'b001000, 5'b00010, 1'b0, 0, 0, '{2'b00, 2'b00, 1'b0, 32'd3, 8'd3, 8'd0, 1'b0}); // BEQ not taken
        chk("br_instret", instret, 32'd4);
        do_instr(6'b000101, 5'b00001, 1'b0, 0, 0, '{2'b10, 2'b10, 1'b1, 32'd4, 8'd4, 8'd0, 1'b0}); // JALR
        do_instr(6'b000110, 5'b00001, 1'b0, 0, 0, '{2'b01, 2'b10, 1'b1, 32'd5, 8'd4, 8'd0, 1'b0}); // JAL
        do_instr(6'b010000, 5'b00001, 1'b0, 0, 0, '{2'b00, 2'b00, 1'b0, 32'd6, 8'd4, 8'd1, 1'b1}); // SW
        do_instr(6'b100100, 5'b00001, 1'b0, 0, 0, '{2'b00, 2'b01, 1'b1, 32'd7, 8'd5, 8'd1, 1'b0}); // LW fast
        dec_AUIPC = 1'b1;
        do_instr(6'b000100, 5'b00001, 1'b0, 2, 0, '{2'b00, 2'b00, 1'b1, 32'd8, 8'd4, 8'd0, 1'b0}); // AUIPC, slow fetch
        dec_AUIPC = 1'b0;
        chk("seq_instret", instret, 32'd9);

        // Illegal opcode halts after DECODE and ignores late ready pulses.
        {dec_load, dec_store, dec_branch, dec_regWrite, dec_JAL, dec_JALR} = '0;
        dec_aluCtrl = 5'b01111;
        imem_ready  = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("ill_decode", 32'(state), 32'd1);
        tick();
        chk("ill_state", 32'(state),   32'd5);
        chk("ill_flag",  32'(illegal), 32'd1);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("halt_strobes", 32'({ir_we, pc_we, rf_we, dmem_req, imem_req, retire, pc_sel, wb_sel}), 32'd0);
            tick();
        end
        chk("halt_state",   32'(state), 32'd5);
        chk("halt_instret", instret,    32'd9);
        imem_ready = 1'b0; dmem_ready = 1'b0;
        dec_aluCtrl = 5'b00001;
        do_reset();
        chk("rst2_state",   32'(state),   32'd0);
        chk("rst2_illegal", 32'(illegal), 32'd0);
        chk("rst2_instret", instret,      32'd0);
        chk("rst2_bus_err", 32'(bus_err), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Fetch starved: four waiting cycles then HALT with bus_err.
        repeat (3) begin tick(); chk("to_wait_state", 32'(state), 32'd0); end
        tick();
        chk("to_state",   32'(state),   32'd5);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        do_reset();
        // Ready arriving in the last allowed cycle wins.
        repeat (3) tick();
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("to_late_state",   32'(state),   32'd1);
        chk("to_late_bus_err", 32'(bus_err), 32'd0);
        do_reset();
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
